ex_mem_reg: RTL and testbench

Parametrised EX/MEM pipeline register for the five-stage core, successor to the basic flop stage. It carries the EX result, destination and write-enable, plus the HI/LO write bundle, into MEM. It adds stall/flush control, bubble insertion, and a held feedback path for multi-cycle EX operations (madd/msub/div accumulation). It sits between the EX stage and the MEM stage and is driven by the central stall controller.

---
 rtl/mips_defs.sv | 23 ++
 rtl/pipe_slot.sv | 29 ++
 rtl/ex_mem_reg.sv | 116 +++++++++++
 tb/tb_ex_mem_reg.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared pipeline constants for the five-stage core.
//   NOP_REG_ADDR / ZERO_WORD : bubble contents (cast to the local width at use)
//   WRITE_ENABLE / WRITE_DISABLE : write-enable / slot-valid levels
//   STALL_*_BIT : bit positions in the stall vector from the stall controller
//   slot_op_e : what a pipeline register does on the next edge
package mips_defs;

  localparam int unsigned NOP_REG_ADDR  = 0;
  localparam int unsigned ZERO_WORD     = 0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  localparam int unsigned STALL_W       = 2;
  localparam int unsigned STALL_EX_BIT  = 0;
  localparam int unsigned STALL_MEM_BIT = 1;

  typedef enum logic [1:0] {
    SLOT_ADVANCE = 2'd0,
    SLOT_BUBBLE  = 2'd1,
    SLOT_HOLD    = 2'd2
  } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// Generic width-parameterised pipeline register.
//   clk, rst  : clock, synchronous active-high reset
//   i_clear   : synchronous clear to zero (beats i_hold)
//   i_hold    : keep current contents
//   i_d / o_q : data in / registered data out
module pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_hold,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, bubble insertion, a held
// feedback path for multi-cycle EX operations and a saturating bubble counter.
//   clk, rst               : clock, synchronous active-high reset
//   stall_ex, stall_mem    : stall controller inputs
//   flush                  : drop the in-flight instruction and feedback state
//   ex_*                   : EX stage results
//   mem_*                  : registered results into MEM, mem_valid marks a real slot
//   hilo_temp_o, cnt_o     : partial accumulation / step index fed back to EX
//   bubble_cnt             : saturating count of inserted bubbles
module ex_mem_reg
  import mips_defs::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 2,
  parameter int unsigned PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_ex,
  input  logic                  stall_mem,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_valid,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [PERF_W-1:0]     bubble_cnt
);

  localparam int unsigned MEM_W = 1 + REG_ADDR_W + 1 + DATA_W + 1 + 2 * DATA_W;
  localparam int unsigned FB_W  = 2 * DATA_W + CNT_W;

  logic [STALL_W-1:0] w_stall;
  slot_op_e           w_op;
  logic [MEM_W-1:0]   w_mem_d;
  logic [MEM_W-1:0]   w_mem_q;
  logic [FB_W-1:0]    w_fb_q;
  logic               w_hold;
  logic               w_fb_clear;
  logic [PERF_W-1:0]  r_bubble_cnt;

  assign w_stall[STALL_EX_BIT]  = stall_ex;
  assign w_stall[STALL_MEM_BIT] = stall_mem;

  // A MEM stall always holds, which also covers the illegal
  // stall_mem-without-stall_ex combination.
  always_comb begin
    w_op = SLOT_ADVANCE;
    if (w_stall[STALL_MEM_BIT]) begin
      w_op = SLOT_HOLD;
    end else if (w_stall[STALL_EX_BIT]) begin
      w_op = SLOT_BUBBLE;
    end
  end

  // The bubble is loaded as data rather than via clear, so the valid bit and
  // both write enables are low whenever the slot is empty.
  always_comb begin
    if (w_op == SLOT_BUBBLE) begin
      w_mem_d = {WRITE_DISABLE, REG_ADDR_W'(NOP_REG_ADDR), WRITE_DISABLE,
                 DATA_W'(ZERO_WORD), WRITE_DISABLE,
                 DATA_W'(ZERO_WORD), DATA_W'(ZERO_WORD)};
    end else begin
      w_mem_d = {WRITE_ENABLE, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo};
    end
  end

  assign w_hold     = (w_op == SLOT_HOLD);
  assign w_fb_clear = flush || (w_op == SLOT_ADVANCE);

  pipe_slot #(.W(MEM_W)) u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .i_clear (flush),
    .i_hold  (w_hold),
    .i_d     (w_mem_d),
    .o_q     (w_mem_q)
  );

  // Feedback only captures on a bubble edge; an advance consumes and clears it.
  pipe_slot #(.W(FB_W)) u_fb_slot (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_fb_clear),
    .i_hold  (w_hold),
    .i_d     ({ex_hilo_temp, ex_cnt}),
    .o_q     (w_fb_q)
  );

  assign {mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo} = w_mem_q;
  assign {hilo_temp_o, cnt_o} = w_fb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!flush && (w_op == SLOT_BUBBLE) && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + PERF_W'(1);
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk;
  logic        rst;
  logic        stall_ex;
  logic        stall_mem;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cnt;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_valid;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;
  logic [1:0]  bubble_cnt;

  ex_mem_reg #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .CNT_W      (2),
    .PERF_W     (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush        (flush),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_whilo     (ex_whilo),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_hilo_temp (ex_hilo_temp),
    .ex_cnt       (ex_cnt),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_valid    (mem_valid),
    .hilo_temp_o  (hilo_temp_o),
    .cnt_o        (cnt_o),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    assert (!(!stall_ex && stall_mem))
      else $error("illegal stall combination: stall_mem without stall_ex");
  end

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [63:0] temp;
    logic [1:0]  cnt;
    logic [1:0]  bcnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_checks;
  int   n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rand_ex();
    ex_wd        = 5'($urandom);
    ex_wreg      = 1'($urandom);
    ex_wdata     = $urandom;
    ex_whilo     = 1'($urandom);
    ex_hi        = $urandom;
    ex_lo        = $urandom;
    ex_hilo_temp = {$urandom, $urandom};
    ex_cnt       = 2'($urandom);
  endtask

  // Build the expected post-edge state from the current inputs, queue it,
  // then clock and compare against the head of the queue.
  task automatic step();
    exp_t e;
    exp_t got;
    if (rst) begin
      e = '0;
    end else if (flush) begin
      e = '0;
      e.bcnt = m.bcnt;
    end else if (!stall_ex && !stall_mem) begin
      e       = '0;
      e.wd    = ex_wd;
      e.wreg  = ex_wreg;
      e.wdata = ex_wdata;
      e.whilo = ex_whilo;
      e.hi    = ex_hi;
      e.lo    = ex_lo;
      e.valid = 1'b1;
      e.bcnt  = m.bcnt;
    end else if (stall_ex && !stall_mem) begin
      e      = '0;
      e.temp = ex_hilo_temp;
      e.cnt  = ex_cnt;
      e.bcnt = (m.bcnt == 2'd3) ? 2'd3 : m.bcnt + 2'd1;
    end else begin
      e = m;
    end
    m = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk("mem_wd",      64'(mem_wd),      64'(got.wd));
      chk("mem_wreg",    64'(mem_wreg),    64'(got.wreg));
      chk("mem_wdata",   64'(mem_wdata),   64'(got.wdata));
      chk("mem_whilo",   64'(mem_whilo),   64'(got.whilo));
      chk("mem_hi",      64'(mem_hi),      64'(got.hi));
      chk("mem_lo",      64'(mem_lo),      64'(got.lo));
      chk("mem_valid",   64'(mem_valid),   64'(got.valid));
      chk("hilo_temp_o", hilo_temp_o,      got.temp);
      chk("cnt_o",       64'(cnt_o),       64'(got.cnt));
      chk("bubble_cnt",  64'(bubble_cnt),  64'(got.bcnt));
      if (!mem_valid) begin
        chk("idle_wreg",  64'(mem_wreg),  64'd0);
        chk("idle_whilo", 64'(mem_whilo), 64'd0);
      end
    end
  endtask

  task automatic set_ctl(input logic r, input logic f, input logic se, input logic sm);
    rst = r; flush = f; stall_ex = se; stall_mem = sm;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] sat_exp [5];
    n_checks = 0;
    n_fail   = 0;
    m        = '0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    rand_ex();
    @(negedge clk);

    // reset with random inputs and a pending stall
    rand_ex();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("rst_valid", 64'(mem_valid), 64'd0);

    // advance
    rand_ex();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
    step();
    chk("adv_wd",    64'(mem_wd),    64'd5);
    chk("adv_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("adv_valid", 64'(mem_valid), 64'd1);

    // bubble with feedback, then consume it
    rand_ex();
    ex_hilo_temp = 64'h0000_0001_0000_0002; ex_cnt = 2'd1;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("bub_temp", hilo_temp_o,       64'h0000_0001_0000_0002);
    chk("bub_cnt",  64'(cnt_o),        64'd1);
    chk("bub_bcnt", 64'(bubble_cnt),   64'd1);
    chk("bub_wreg", 64'(mem_wreg),     64'd0);
    rand_ex();
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("consume_cnt", 64'(cnt_o), 64'd0);

    // hold for three cycles while EX data changes
    rand_ex();
    ex_wdata = 32'h0000_1234;
    step();
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
      step();
    end
    chk("hold_wdata", 64'(mem_wdata),  64'h1234);
    chk("hold_bcnt",  64'(bubble_cnt), 64'd1);

    // flush over a held multi-cycle step
    rand_ex();
    ex_cnt = 2'd1;
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("pre_flush_cnt", 64'(cnt_o), 64'd1);
    rand_ex();
    set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush_cnt",   64'(cnt_o),      64'd0);
    chk("flush_valid", 64'(mem_valid),  64'd0);
    chk("flush_bcnt",  64'(bubble_cnt), 64'd2);

    // reset mid-stall
    rand_ex();
    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("rst_stall_bcnt", 64'(bubble_cnt), 64'd0);

    // saturation of the 2-bit bubble counter
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      rand_ex();
      set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      chk($sformatf("sat_%0d", i), 64'(bubble_cnt), 64'(sat_exp[i]));
    end

    // random legal traffic
    for (int i = 0; i < 60; i++) begin
      int unsigned sel;
      rand_ex();
      sel = $urandom_range(0, 2);
      rst   = ($urandom_range(0, 15) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall_ex  = (sel != 0);
      stall_mem = (sel == 2);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
